// File: rtl/pwm_oc_dt_pkg.sv
// Shared state encoding and bus-slicing helper for the complementary deadtime generator.
package pwm_oc_dt_pkg;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_LOW     = 3'd1,
        S_DT_RISE = 3'd2,
        S_HIGH    = 3'd3,
        S_DT_FALL = 3'd4
    } dt_state_t;

    // LSB index of channel ch inside a packed per-channel bus, ch0 in the LSBs.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/pwm_oc_deadtime_ch.sv
// One channel: shadowed rise/fall deadtimes, deadtime counter and the Moore FSM.
// The registered FSM state is the only output; the top decodes drives from it.
module pwm_oc_deadtime_ch
    import pwm_oc_dt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update_event,
    input  logic             pwm_in,
    input  logic             en,
    input  logic [WIDTH-1:0] rise_preload,
    input  logic [WIDTH-1:0] fall_preload,
    output dt_state_t        state
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    dt_state_t        state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] rise_sh, fall_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_OFF;
            cnt     <= '0;
            rise_sh <= '0;
            fall_sh <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            // Shadows only feed the next counter load, so a running deadtime is unaffected.
            if (update_event) begin
                rise_sh <= rise_preload;
                fall_sh <= fall_preload;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!en) begin
            state_nx = S_OFF;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                S_OFF, S_LOW, S_HIGH: begin
                    if (pwm_in && state != S_HIGH) begin
                        if (rise_sh == '0) begin
                            state_nx = S_HIGH;
                        end else begin
                            state_nx = S_DT_RISE;
                            cnt_nx   = rise_sh - ONE;
                        end
                    end else if (!pwm_in && state != S_LOW) begin
                        if (fall_sh == '0) begin
                            state_nx = S_LOW;
                        end else begin
                            state_nx = S_DT_FALL;
                            cnt_nx   = fall_sh - ONE;
                        end
                    end
                end
                S_DT_RISE: begin
                    // A pulse shorter than the deadtime is swallowed; low side resumes at once.
                    if (!pwm_in) begin
                        state_nx = S_LOW;
                        cnt_nx   = '0;
                    end else if (cnt == '0) begin
                        state_nx = S_HIGH;
                    end else begin
                        cnt_nx = cnt - ONE;
                    end
                end
                S_DT_FALL: begin
                    if (pwm_in) begin
                        state_nx = S_HIGH;
                        cnt_nx   = '0;
                    end else if (cnt == '0) begin
                        state_nx = S_LOW;
                    end else begin
                        cnt_nx = cnt - ONE;
                    end
                end
                default: begin
                    state_nx = S_OFF;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_oc_deadtime_mc.sv
// Multi-channel complementary deadtime generator: break gating, per-channel FSMs, polarity.
// Optional macro PWM_OC_DT_BREAK_LATCH_EN makes break sticky until break_clr_i.
module pwm_oc_deadtime_mc
    import pwm_oc_dt_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 8
) (
    input  logic                    clk_psc_i,
    input  logic                    rst_i,
    input  logic                    update_event_i,
    input  logic [NUM_CH-1:0]       pwm_in_i,
    input  logic [NUM_CH*WIDTH-1:0] dtg_rise_preload_i,
    input  logic [NUM_CH*WIDTH-1:0] dtg_fall_preload_i,
    input  logic [NUM_CH-1:0]       out_en_i,
    input  logic [NUM_CH-1:0]       pol_high_i,
    input  logic [NUM_CH-1:0]       pol_low_i,
    input  logic                    break_i,
`ifdef PWM_OC_DT_BREAK_LATCH_EN
    input  logic                    break_clr_i,
    output logic                    break_flag_o,
`endif
    output logic [NUM_CH-1:0]       pwm_high_o,
    output logic [NUM_CH-1:0]       pwm_low_o,
    output logic [NUM_CH-1:0]       dt_busy_o
);

    logic              brk;
    logic [NUM_CH-1:0] en;
    dt_state_t         ch_state [NUM_CH];

`ifdef PWM_OC_DT_BREAK_LATCH_EN
    logic break_flag;

    // Set wins over clear, so a clear while break_i is still high has no effect.
    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            break_flag <= 1'b0;
        end else if (break_i) begin
            break_flag <= 1'b1;
        end else if (break_clr_i) begin
            break_flag <= 1'b0;
        end
    end

    assign brk          = break_flag | break_i;
    assign break_flag_o = break_flag;
`else
    assign brk = break_i;
`endif

    assign en = out_en_i & ~{NUM_CH{brk}};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pwm_oc_deadtime_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk          (clk_psc_i),
            .rst          (rst_i),
            .update_event (update_event_i),
            .pwm_in       (pwm_in_i[ch]),
            .en           (en[ch]),
            .rise_preload (dtg_rise_preload_i[ch_lsb(ch, WIDTH) +: WIDTH]),
            .fall_preload (dtg_fall_preload_i[ch_lsb(ch, WIDTH) +: WIDTH]),
            .state        (ch_state[ch])
        );

        assign pwm_high_o[ch] = (ch_state[ch] == S_HIGH) ^ pol_high_i[ch];
        assign pwm_low_o[ch]  = (ch_state[ch] == S_LOW) ^ pol_low_i[ch];
        assign dt_busy_o[ch]  = (ch_state[ch] == S_DT_RISE) || (ch_state[ch] == S_DT_FALL);
    end

endmodule

// File: tb/tb_pwm_oc_deadtime_mc.sv
// Bench for pwm_oc_deadtime_mc: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a side/remaining-deadtime model.
module tb_pwm_oc_deadtime_mc;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 8;
    localparam int NONE   = 0;
    localparam int LO     = 1;
    localparam int HI     = 2;

    logic                    clk_psc_i = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    update_event_i = 1'b0;
    logic [NUM_CH-1:0]       pwm_in_i = '0;
    logic [NUM_CH*WIDTH-1:0] dtg_rise_preload_i = '0;
    logic [NUM_CH*WIDTH-1:0] dtg_fall_preload_i = '0;
    logic [NUM_CH-1:0]       out_en_i = '0;
    logic [NUM_CH-1:0]       pol_high_i = '0;
    logic [NUM_CH-1:0]       pol_low_i = '0;
    logic                    break_i = 1'b0;
    logic                    break_clr_i = 1'b0;
    logic                    break_flag_o;
    logic [NUM_CH-1:0]       pwm_high_o;
    logic [NUM_CH-1:0]       pwm_low_o;
    logic [NUM_CH-1:0]       dt_busy_o;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk_psc_i = ~clk_psc_i;

    pwm_oc_deadtime_mc #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk_psc_i          (clk_psc_i),
        .rst_i              (rst_i),
        .update_event_i     (update_event_i),
        .pwm_in_i           (pwm_in_i),
        .dtg_rise_preload_i (dtg_rise_preload_i),
        .dtg_fall_preload_i (dtg_fall_preload_i),
        .out_en_i           (out_en_i),
        .pol_high_i         (pol_high_i),
        .pol_low_i          (pol_low_i),
        .break_i            (break_i),
`ifdef PWM_OC_DT_BREAK_LATCH_EN
        .break_clr_i        (break_clr_i),
        .break_flag_o       (break_flag_o),
`endif
        .pwm_high_o         (pwm_high_o),
        .pwm_low_o          (pwm_low_o),
        .dt_busy_o          (dt_busy_o)
    );

`ifndef PWM_OC_DT_BREAK_LATCH_EN
    assign break_flag_o = 1'b0;
`endif

    // ---------------- reference model ----------------
    // Per channel: which side is driven, which side a pending deadtime leads to,
    // and how many both-off cycles remain.
    int  m_on   [NUM_CH];
    int  m_side [NUM_CH];
    int  m_pend [NUM_CH];
    int  m_left [NUM_CH];
    int  m_shr  [NUM_CH];
    int  m_shf  [NUM_CH];
    bit  m_flag;

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_on[c] = 0; m_side[c] = NONE; m_pend[c] = NONE;
            m_left[c] = 0; m_shr[c] = 0; m_shf[c] = 0;
        end
        m_flag = 1'b0;
    end

    always @(posedge clk_psc_i) begin
        int want;
        int dt;
        bit brk;
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_on[c] = 0; m_side[c] = NONE; m_pend[c] = NONE;
                m_left[c] = 0; m_shr[c] = 0; m_shf[c] = 0;
            end
            m_flag = 1'b0;
        end else begin
`ifdef PWM_OC_DT_BREAK_LATCH_EN
            brk = break_i | m_flag;
`else
            brk = break_i;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                want = pwm_in_i[c] ? HI : LO;
                if (!out_en_i[c] || brk) begin
                    m_on[c] = 0; m_side[c] = NONE; m_pend[c] = NONE; m_left[c] = 0;
                end else if (m_pend[c] != NONE) begin
                    if (want != m_pend[c]) begin
                        m_side[c] = want; m_pend[c] = NONE; m_left[c] = 0;
                    end else begin
                        m_left[c] = m_left[c] - 1;
                        if (m_left[c] == 0) begin
                            m_side[c] = m_pend[c]; m_pend[c] = NONE;
                        end
                    end
                end else if (m_on[c] == 0 || m_side[c] != want) begin
                    m_on[c] = 1;
                    dt = (want == HI) ? m_shr[c] : m_shf[c];
                    if (dt == 0) begin
                        m_side[c] = want;
                    end else begin
                        m_side[c] = NONE; m_pend[c] = want; m_left[c] = dt;
                    end
                end
            end
            if (break_i) m_flag = 1'b1;
            else if (break_clr_i) m_flag = 1'b0;
            if (update_event_i) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    m_shr[c] = int'(dtg_rise_preload_i[c*WIDTH +: WIDTH]);
                    m_shf[c] = int'(dtg_fall_preload_i[c*WIDTH +: WIDTH]);
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_psc_i) begin
        logic [NUM_CH-1:0] eh, el, eb;
        if (chk_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                eh[c] = (m_side[c] == HI) ^ pol_high_i[c];
                el[c] = (m_side[c] == LO) ^ pol_low_i[c];
                eb[c] = (m_pend[c] != NONE);
            end
            chk("model_pwm_high", 32'(pwm_high_o), 32'(eh));
            chk("model_pwm_low", 32'(pwm_low_o), 32'(el));
            chk("model_dt_busy", 32'(dt_busy_o), 32'(eb));
            chk("raw_overlap", 32'((pwm_high_o ^ pol_high_i) & (pwm_low_o ^ pol_low_i)), 32'd0);
`ifdef PWM_OC_DT_BREAK_LATCH_EN
            chk("model_break_flag", 32'(break_flag_o), 32'(m_flag));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_psc_i);
        #2;
    endtask

    task automatic load_dt(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] f);
        dtg_rise_preload_i = {NUM_CH{r}};
        dtg_fall_preload_i = {NUM_CH{f}};
        update_event_i = 1'b1;
        tick();
        update_event_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        pol_high_i = 3'b101;
        pol_low_i  = 3'b011;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_high", 32'(pwm_high_o), 32'h5);
        chk("reset_low", 32'(pwm_low_o), 32'h3);
        chk("reset_busy", 32'(dt_busy_o), 32'h0);
        rst_i = 1'b0;

        // Scenario 1: rise 4, fall 2
        pol_high_i = '0;
        pol_low_i  = '0;
        out_en_i   = 3'b111;
        load_dt(8'd4, 8'd2);
        tick();
        chk("s1_low_idle", 32'(pwm_low_o[0]), 32'd1);
        pwm_in_i[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s1_rise_busy", 32'({dt_busy_o[0], pwm_high_o[0], pwm_low_o[0]}), 32'b100);
        end
        tick();
        chk("s1_high_on", 32'({dt_busy_o[0], pwm_high_o[0], pwm_low_o[0]}), 32'b010);
        pwm_in_i[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("s1_fall_busy", 32'({dt_busy_o[0], pwm_high_o[0], pwm_low_o[0]}), 32'b100);
        end
        tick();
        chk("s1_low_on", 32'({dt_busy_o[0], pwm_high_o[0], pwm_low_o[0]}), 32'b001);

        // Scenario 2: zero deadtime toggles one cycle after the sampled edge
        load_dt(8'd0, 8'd0);
        pwm_in_i = 3'b111;
        tick();
        chk("s2_high", 32'(pwm_high_o), 32'h7);
        chk("s2_busy", 32'(dt_busy_o), 32'h0);
        pwm_in_i = 3'b000;
        tick();
        chk("s2_low", 32'(pwm_low_o), 32'h7);

        // Scenario 3: pulse shorter than deadtime is swallowed
        load_dt(8'd10, 8'd0);
        pwm_in_i[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s3_no_high", 32'(pwm_high_o[1]), 32'd0);
        end
        pwm_in_i[1] = 1'b0;
        tick();
        chk("s3_low_back", 32'({dt_busy_o[1], pwm_low_o[1]}), 32'b01);

        // Scenario 4: break mid S_HIGH
        load_dt(8'd0, 8'd0);
        pwm_in_i = 3'b111;
        tick();
        pol_high_i = 3'b111;
        pol_low_i  = 3'b000;
        break_i = 1'b1;
        dtg_rise_preload_i = {NUM_CH{8'd3}};
        update_event_i = 1'b1;
        tick();
        break_i = 1'b0;
        update_event_i = 1'b0;
        chk("s4_brk_high", 32'(pwm_high_o), 32'h7);
        chk("s4_brk_low", 32'(pwm_low_o), 32'h0);
`ifdef PWM_OC_DT_BREAK_LATCH_EN
        tick();
        chk("s4_latched", 32'({break_flag_o, dt_busy_o}), 32'b1000);
        break_clr_i = 1'b1;
        tick();
        break_clr_i = 1'b0;
`endif
        tick();
        chk("s4_reenter", 32'(dt_busy_o), 32'h7);

        // Scenario 5: shadow update during a running rise deadtime
        pol_high_i = '0;
        load_dt(8'd4, 8'd0);
        pwm_in_i = 3'b000;
        tick();
        pwm_in_i[0] = 1'b1;
        tick();
        tick();
        dtg_rise_preload_i = {NUM_CH{8'd7}};
        update_event_i = 1'b1;
        tick();
        update_event_i = 1'b0;
        tick();
        chk("s5_still_busy", 32'({dt_busy_o[0], pwm_high_o[0]}), 32'b10);
        tick();
        chk("s5_old_dt", 32'({dt_busy_o[0], pwm_high_o[0]}), 32'b01);
        pwm_in_i[0] = 1'b0;
        tick();
        pwm_in_i[0] = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("s5_new_busy", 32'({dt_busy_o[0], pwm_high_o[0]}), 32'b10);
        tick();
        chk("s5_new_dt", 32'({dt_busy_o[0], pwm_high_o[0]}), 32'b01);

        // Scenario 6: randomized traffic checked every cycle by the model
        for (int n = 0; n < 20000; n++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 7) == 0) pwm_in_i[c] = ~pwm_in_i[c];
                if ($urandom_range(0, 99) == 0) out_en_i[c] = ~out_en_i[c];
                if ($urandom_range(0, 499) == 0) pol_high_i[c] = ~pol_high_i[c];
                if ($urandom_range(0, 499) == 0) pol_low_i[c] = ~pol_low_i[c];
            end
            update_event_i = ($urandom_range(0, 29) == 0);
            if (update_event_i) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    dtg_rise_preload_i[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 9));
                    dtg_fall_preload_i[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 9));
                end
            end
            break_i     = ($urandom_range(0, 299) == 0);
            break_clr_i = ($urandom_range(0, 19) == 0);
            rst_i       = ($urandom_range(0, 2999) == 0);
        end
        rst_i = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
